// File: rtl/lsu_ctrl_pkg.sv
// Shared widths, size codes, FSM encoding and command record for the LSU controller.
// Pure declarations: no latency, no flow control.
// Imported by every lsu_ctrl file so widths and encodings stay in one place.
package lsu_ctrl_pkg;

  localparam int XLEN            = 32;
  localparam int ITAG_WIDTH      = 4;
  localparam int DTCM_ADDR_WIDTH = 16;
  localparam int WMASK_WIDTH     = XLEN / 8;

  localparam logic [1:0] LSU_SIZE_B = 2'd0;
  localparam logic [1:0] LSU_SIZE_H = 2'd1;
  localparam logic [1:0] LSU_SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2,
    ST_OUT  = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic [DTCM_ADDR_WIDTH-1:0] addr;
    logic                       read;
    logic [1:0]                 size;
    logic                       usign;
    logic [ITAG_WIDTH-1:0]      itag;
    logic [XLEN-1:0]            wdata;
    logic [WMASK_WIDTH-1:0]     wmask;
  } lsu_cmd_t;

endpackage

// File: rtl/lsu_ctrl_if.sv
// Bundle of the AGU, write-back and DTCM handshakes around the LSU controller.
// Wires only: no latency, no storage.
// master = controller view, slave = surrounding AGU/EXU/DTCM view.
interface lsu_ctrl_if;
  import lsu_ctrl_pkg::*;

  logic                       agu_cmd_valid;
  logic                       agu_cmd_ready;
  logic [DTCM_ADDR_WIDTH-1:0] agu_cmd_addr;
  logic                       agu_cmd_read;
  logic [1:0]                 agu_cmd_size;
  logic                       agu_cmd_usign;
  logic [ITAG_WIDTH-1:0]      agu_cmd_itag;
  logic [XLEN-1:0]            agu_cmd_wdata;
  logic [WMASK_WIDTH-1:0]     agu_cmd_wmask;

  logic                       agu_rsp_valid;
  logic                       agu_rsp_ready;

  logic                       lsu_wbck_o_valid;
  logic                       lsu_wbck_o_ready;
  logic [XLEN-1:0]            lsu_wbck_o_data;
  logic [ITAG_WIDTH-1:0]      lsu_wbck_o_itag;

  logic                       dtcm_cmd_valid;
  logic                       dtcm_cmd_ready;
  logic [DTCM_ADDR_WIDTH-1:0] dtcm_cmd_addr;
  logic                       dtcm_cmd_read;
  logic [XLEN-1:0]            dtcm_cmd_wdata;
  logic [WMASK_WIDTH-1:0]     dtcm_cmd_wmask;

  logic                       dtcm_rsp_valid;
  logic                       dtcm_rsp_ready;
  logic [XLEN-1:0]            dtcm_rsp_rdata;

  modport master (
    input  agu_cmd_valid, agu_cmd_addr, agu_cmd_read, agu_cmd_size, agu_cmd_usign,
    input  agu_cmd_itag, agu_cmd_wdata, agu_cmd_wmask,
    output agu_cmd_ready,
    output agu_rsp_valid, input agu_rsp_ready,
    output lsu_wbck_o_valid, lsu_wbck_o_data, lsu_wbck_o_itag, input lsu_wbck_o_ready,
    output dtcm_cmd_valid, dtcm_cmd_addr, dtcm_cmd_read, dtcm_cmd_wdata, dtcm_cmd_wmask,
    input  dtcm_cmd_ready,
    input  dtcm_rsp_valid, dtcm_rsp_rdata, output dtcm_rsp_ready
  );

  modport slave (
    output agu_cmd_valid, agu_cmd_addr, agu_cmd_read, agu_cmd_size, agu_cmd_usign,
    output agu_cmd_itag, agu_cmd_wdata, agu_cmd_wmask,
    input  agu_cmd_ready,
    input  agu_rsp_valid, output agu_rsp_ready,
    input  lsu_wbck_o_valid, lsu_wbck_o_data, lsu_wbck_o_itag, output lsu_wbck_o_ready,
    input  dtcm_cmd_valid, dtcm_cmd_addr, dtcm_cmd_read, dtcm_cmd_wdata, dtcm_cmd_wmask,
    output dtcm_cmd_ready,
    output dtcm_rsp_valid, dtcm_rsp_rdata, input dtcm_rsp_ready
  );

endinterface

// File: rtl/lsu_ld_align.sv
// Load data align/extend: picks byte/halfword at the address offset and sign/zero extends.
// Combinational, zero cycles.
// No flow control; the caller decides when the result is captured.
module lsu_ld_align
  import lsu_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      ofs,
  input  logic [1:0]      size,
  input  logic            usign,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Halfwords use only ofs[1]; misaligned halfwords are not trapped here.
  assign byte_v = 8'(rdata >> {ofs, 3'b000});
  assign half_v = 16'(rdata >> {ofs[1], 4'b0000});

  always_comb begin
    data = rdata;
    case (size)
      LSU_SIZE_B: data = {{(XLEN-8){byte_v[7] & ~usign}}, byte_v};
      LSU_SIZE_H: data = {{(XLEN-16){half_v[15] & ~usign}}, half_v};
      default:    data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Single-outstanding LSU controller: AGU command -> DTCM request -> load write-back or store ack.
// Latency: accept N, dtcm_cmd N+1, dtcm_rsp N+2, output N+3 with zero-wait DTCM (LSU_B2B_EN removes the idle bubble).
// Backpressure: every valid holds with stable registered fields until its ready; agu_cmd_ready only when free.
module lsu_ctrl
  import lsu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  lsu_ctrl_if.master bus
);

  lsu_state_e      state_q, state_d;
  lsu_cmd_t        cmd_q, cmd_d, cmd_in;
  logic [XLEN-1:0] res_q, res_d;
  logic [XLEN-1:0] ld_data;
  logic            out_done;

  assign cmd_in.addr  = bus.agu_cmd_addr;
  assign cmd_in.read  = bus.agu_cmd_read;
  assign cmd_in.size  = bus.agu_cmd_size;
  assign cmd_in.usign = bus.agu_cmd_usign;
  assign cmd_in.itag  = bus.agu_cmd_itag;
  assign cmd_in.wdata = bus.agu_cmd_wdata;
  assign cmd_in.wmask = bus.agu_cmd_wmask;

  lsu_ld_align u_ld_align (
    .rdata (bus.dtcm_rsp_rdata),
    .ofs   (cmd_q.addr[1:0]),
    .size  (cmd_q.size),
    .usign (cmd_q.usign),
    .data  (ld_data)
  );

  // Bus-facing fields come straight from flops so they cannot move under backpressure.
  assign bus.dtcm_cmd_addr   = cmd_q.addr;
  assign bus.dtcm_cmd_read   = cmd_q.read;
  assign bus.dtcm_cmd_wdata  = cmd_q.wdata;
  assign bus.dtcm_cmd_wmask  = cmd_q.wmask;
  assign bus.lsu_wbck_o_data = res_q;
  assign bus.lsu_wbck_o_itag = cmd_q.itag;

  always_comb begin
    state_d              = state_q;
    cmd_d                = cmd_q;
    res_d                = res_q;
    out_done             = 1'b0;
    bus.agu_cmd_ready    = 1'b0;
    bus.dtcm_cmd_valid   = 1'b0;
    bus.dtcm_rsp_ready   = 1'b0;
    bus.lsu_wbck_o_valid = 1'b0;
    bus.agu_rsp_valid    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.agu_cmd_ready = 1'b1;
        if (bus.agu_cmd_valid) begin
          cmd_d   = cmd_in;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        bus.dtcm_cmd_valid = 1'b1;
        if (bus.dtcm_cmd_ready) state_d = ST_RSP;
      end
      ST_RSP: begin
        bus.dtcm_rsp_ready = 1'b1;
        if (bus.dtcm_rsp_valid) begin
          res_d   = ld_data;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        bus.lsu_wbck_o_valid = cmd_q.read;
        bus.agu_rsp_valid    = ~cmd_q.read;
        out_done             = cmd_q.read ? bus.lsu_wbck_o_ready : bus.agu_rsp_ready;
        if (out_done) begin
          state_d = ST_IDLE;
`ifdef LSU_B2B_EN
          bus.agu_cmd_ready = 1'b1;
          if (bus.agu_cmd_valid) begin
            cmd_d   = cmd_in;
            state_d = ST_REQ;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: latency, load extension, store ack, backpressure, reset, back-to-back.
// Expected values are hand-derived constants; LSU_B2B_EN selects the expected command gap.
module tb_lsu_ctrl;
  import lsu_ctrl_pkg::*;

`ifdef LSU_B2B_EN
  localparam int EXP_GAP = 3;
`else
  localparam int EXP_GAP = 4;
`endif

  typedef struct {
    logic        c0_rdy;
    logic        c1_vld;
    logic [15:0] c1_addr;
    logic        c1_read;
    logic [31:0] c1_wdata;
    logic [3:0]  c1_wmask;
    logic        c2_rrdy;
    logic        c3_wb_vld;
    logic [31:0] c3_wb_dat;
    logic [3:0]  c3_wb_itag;
    logic        c3_rsp_vld;
    logic        c4_wb_vld;
    logic        c4_rsp_vld;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vecs = 0;
  int   miss = 0;

  lsu_ctrl_if bus ();

  lsu_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives one transaction against a zero-wait DTCM and records what each cycle showed.
  task automatic zw_txn(input logic rd, input logic [15:0] addr, input logic [1:0] size,
                        input logic usign, input logic [3:0] itag, input logic [31:0] wdata,
                        input logic [3:0] wmask, input logic [31:0] rdata, output obs_t o);
    bus.agu_cmd_valid = 1'b1;  bus.agu_cmd_read = rd;    bus.agu_cmd_addr = addr;
    bus.agu_cmd_size  = size;  bus.agu_cmd_usign = usign; bus.agu_cmd_itag = itag;
    bus.agu_cmd_wdata = wdata; bus.agu_cmd_wmask = wmask;
    bus.dtcm_cmd_ready = 1'b1; bus.lsu_wbck_o_ready = 1'b1; bus.agu_rsp_ready = 1'b1;
    bus.dtcm_rsp_valid = 1'b0;
    @(negedge clk);
    o.c0_rdy = bus.agu_cmd_ready;
    cyc();
    bus.agu_cmd_valid = 1'b0;
    @(negedge clk);
    o.c1_vld = bus.dtcm_cmd_valid; o.c1_addr = bus.dtcm_cmd_addr; o.c1_read = bus.dtcm_cmd_read;
    o.c1_wdata = bus.dtcm_cmd_wdata; o.c1_wmask = bus.dtcm_cmd_wmask;
    cyc();
    bus.dtcm_rsp_valid = 1'b1; bus.dtcm_rsp_rdata = rdata;
    @(negedge clk);
    o.c2_rrdy = bus.dtcm_rsp_ready;
    cyc();
    bus.dtcm_rsp_valid = 1'b0;
    @(negedge clk);
    o.c3_wb_vld = bus.lsu_wbck_o_valid; o.c3_wb_dat = bus.lsu_wbck_o_data;
    o.c3_wb_itag = bus.lsu_wbck_o_itag; o.c3_rsp_vld = bus.agu_rsp_valid;
    cyc();
    @(negedge clk);
    o.c4_wb_vld = bus.lsu_wbck_o_valid; o.c4_rsp_vld = bus.agu_rsp_valid;
    cyc();
  endtask

  task automatic test_reset();
    @(negedge clk);
    vecs++;
    if ({bus.dtcm_cmd_valid, bus.dtcm_rsp_ready, bus.lsu_wbck_o_valid, bus.agu_rsp_valid} !== 4'b0000) begin
      miss++;
      $display("FAIL rst_valids got %b expected 0000",
               {bus.dtcm_cmd_valid, bus.dtcm_rsp_ready, bus.lsu_wbck_o_valid, bus.agu_rsp_valid});
    end
    vecs++;
    if (bus.agu_cmd_ready !== 1'b1) begin
      miss++; $display("FAIL rst_cmd_ready got %b expected 1", bus.agu_cmd_ready);
    end
    vecs++;
    if ({bus.dtcm_cmd_addr, bus.dtcm_cmd_wdata, bus.lsu_wbck_o_data} !== 80'h0) begin
      miss++;
      $display("FAIL rst_fields got %h/%h/%h expected 0", bus.dtcm_cmd_addr, bus.dtcm_cmd_wdata,
               bus.lsu_wbck_o_data);
    end
  endtask

  task automatic test_load_word();
    obs_t o;
    zw_txn(1'b1, 16'h0010, LSU_SIZE_W, 1'b0, 4'd2, 32'h0, 4'h0, 32'hDEADBEEF, o);
    vecs++;
    if (o.c0_rdy !== 1'b1) begin miss++; $display("FAIL ldw_accept got %b expected 1", o.c0_rdy); end
    vecs++;
    if ({o.c1_vld, o.c1_addr, o.c1_read} !== {1'b1, 16'h0010, 1'b1}) begin
      miss++; $display("FAIL ldw_dtcm_cmd got %b %h %b expected 1 0010 1", o.c1_vld, o.c1_addr, o.c1_read);
    end
    vecs++;
    if (o.c2_rrdy !== 1'b1) begin miss++; $display("FAIL ldw_rsp_ready got %b expected 1", o.c2_rrdy); end
    vecs++;
    if ({o.c3_wb_vld, o.c3_wb_dat, o.c3_wb_itag} !== {1'b1, 32'hDEADBEEF, 4'd2}) begin
      miss++; $display("FAIL ldw_wbck got %b %h %0d expected 1 deadbeef 2", o.c3_wb_vld, o.c3_wb_dat, o.c3_wb_itag);
    end
    vecs++;
    if ({o.c3_rsp_vld, o.c4_wb_vld} !== 2'b00) begin
      miss++; $display("FAIL ldw_after got rsp=%b wb_next=%b expected 0 0", o.c3_rsp_vld, o.c4_wb_vld);
    end
  endtask

  task automatic test_load_extend();
    obs_t o;
    logic [15:0] addr_t [6] = '{16'h0013, 16'h0013, 16'h0012, 16'h0010, 16'h0010, 16'h0011};
    logic [1:0]  size_t [6] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd3};
    logic        usgn_t [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] rd_t   [6] = '{32'h80FFFFFF, 32'h80FFFFFF, 32'h80011234, 32'h0000F00D,
                                32'h0000F00D, 32'h87654321};
    logic [31:0] exp_t  [6] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h0000F00D,
                                32'hFFFFF00D, 32'h87654321};
    for (int i = 0; i < 6; i++) begin
      zw_txn(1'b1, addr_t[i], size_t[i], usgn_t[i], 4'(i + 8), 32'h0, 4'h0, rd_t[i], o);
      vecs++;
      if ({o.c3_wb_vld, o.c3_wb_dat} !== {1'b1, exp_t[i]}) begin
        miss++; $display("FAIL ld_ext[%0d] got %b %h expected 1 %h", i, o.c3_wb_vld, o.c3_wb_dat, exp_t[i]);
      end
    end
    vecs++;
    if (o.c1_addr !== 16'h0011) begin
      miss++; $display("FAIL ld_addr_lsbs got %h expected 0011", o.c1_addr);
    end
  endtask

  task automatic test_store();
    obs_t o;
    zw_txn(1'b0, 16'h0020, LSU_SIZE_W, 1'b0, 4'd3, 32'h0000ABCD, 4'b0011, 32'h55555555, o);
    vecs++;
    if ({o.c1_vld, o.c1_addr, o.c1_read, o.c1_wdata, o.c1_wmask} !==
        {1'b1, 16'h0020, 1'b0, 32'h0000ABCD, 4'b0011}) begin
      miss++;
      $display("FAIL st_dtcm_cmd got %b %h %b %h %b expected 1 0020 0 0000abcd 0011",
               o.c1_vld, o.c1_addr, o.c1_read, o.c1_wdata, o.c1_wmask);
    end
    vecs++;
    if ({o.c3_rsp_vld, o.c4_rsp_vld} !== 2'b10) begin
      miss++; $display("FAIL st_rsp_pulse got %b%b expected 10", o.c3_rsp_vld, o.c4_rsp_vld);
    end
    vecs++;
    if ({o.c3_wb_vld, o.c4_wb_vld} !== 2'b00) begin
      miss++; $display("FAIL st_no_wbck got %b%b expected 00", o.c3_wb_vld, o.c4_wb_vld);
    end
  endtask

  task automatic test_backpressure();
    int nwb = 0;
    bus.agu_cmd_valid = 1'b1; bus.agu_cmd_read = 1'b1; bus.agu_cmd_addr = 16'h0044;
    bus.agu_cmd_size = LSU_SIZE_W; bus.agu_cmd_usign = 1'b0; bus.agu_cmd_itag = 4'd7;
    bus.dtcm_cmd_ready = 1'b0; bus.lsu_wbck_o_ready = 1'b0; bus.dtcm_rsp_valid = 1'b0;
    cyc();
    bus.agu_cmd_valid = 1'b0; bus.agu_cmd_addr = 16'h0FF0; bus.agu_cmd_itag = 4'd1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) bus.dtcm_cmd_ready = 1'b1;
      @(negedge clk);
      vecs++;
      if ({bus.dtcm_cmd_valid, bus.dtcm_cmd_addr, bus.dtcm_cmd_read} !== {1'b1, 16'h0044, 1'b1}) begin
        miss++;
        $display("FAIL bp_cmd_hold[%0d] got %b %h %b expected 1 0044 1", i, bus.dtcm_cmd_valid,
                 bus.dtcm_cmd_addr, bus.dtcm_cmd_read);
      end
      cyc();
    end
    bus.dtcm_cmd_ready = 1'b0; bus.dtcm_rsp_valid = 1'b1; bus.dtcm_rsp_rdata = 32'h12345678;
    cyc();
    bus.dtcm_rsp_valid = 1'b0; bus.dtcm_rsp_rdata = 32'hFFFFFFFF;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) bus.lsu_wbck_o_ready = 1'b1;
      @(negedge clk);
      if (i < 3) begin
        vecs++;
        if ({bus.lsu_wbck_o_valid, bus.lsu_wbck_o_data, bus.lsu_wbck_o_itag} !== {1'b1, 32'h12345678, 4'd7}) begin
          miss++;
          $display("FAIL bp_wb_hold[%0d] got %b %h %0d expected 1 12345678 7", i,
                   bus.lsu_wbck_o_valid, bus.lsu_wbck_o_data, bus.lsu_wbck_o_itag);
        end
      end
      if (bus.lsu_wbck_o_valid && bus.lsu_wbck_o_ready) nwb++;
      cyc();
    end
    vecs++;
    if (nwb !== 1) begin miss++; $display("FAIL bp_wb_count got %0d expected 1", nwb); end
  endtask

  task automatic test_reset_mid();
    int nout = 0;
    bus.agu_cmd_valid = 1'b1; bus.agu_cmd_read = 1'b1; bus.agu_cmd_addr = 16'h0030;
    bus.agu_cmd_size = LSU_SIZE_W; bus.agu_cmd_itag = 4'd9;
    bus.dtcm_cmd_ready = 1'b1; bus.lsu_wbck_o_ready = 1'b1; bus.agu_rsp_ready = 1'b1;
    bus.dtcm_rsp_valid = 1'b0;
    cyc();
    bus.agu_cmd_valid = 1'b0;
    cyc();
    #2;
    vecs++;
    if (bus.dtcm_rsp_ready !== 1'b1) begin
      miss++; $display("FAIL rm_in_rsp got %b expected 1", bus.dtcm_rsp_ready);
    end
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({bus.dtcm_cmd_valid, bus.dtcm_rsp_ready, bus.lsu_wbck_o_valid, bus.agu_rsp_valid,
         bus.dtcm_cmd_addr} !== {4'b0000, 16'h0000}) begin
      miss++;
      $display("FAIL rm_async got %b%b%b%b %h expected 0000 0000", bus.dtcm_cmd_valid,
               bus.dtcm_rsp_ready, bus.lsu_wbck_o_valid, bus.agu_rsp_valid, bus.dtcm_cmd_addr);
    end
    cyc();
    rst_n = 1'b1;
    bus.dtcm_rsp_valid = 1'b1; bus.dtcm_rsp_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.lsu_wbck_o_valid || bus.agu_rsp_valid || bus.dtcm_rsp_ready) nout++;
      cyc();
    end
    bus.dtcm_rsp_valid = 1'b0;
    vecs++;
    if (nout !== 0) begin miss++; $display("FAIL rm_stray_out got %0d expected 0", nout); end
    @(negedge clk);
    vecs++;
    if (bus.agu_cmd_ready !== 1'b1) begin
      miss++; $display("FAIL rm_idle_ready got %b expected 1", bus.agu_cmd_ready);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    int hs1 = -100, hs2 = -100, nhs = 0, acc = 0, nwb = 0;
    logic hs_prev = 1'b0;
    logic [3:0]  wb_itag [2];
    logic [31:0] wb_dat  [2];
    bus.dtcm_cmd_ready = 1'b1; bus.lsu_wbck_o_ready = 1'b1;
    bus.agu_cmd_read = 1'b1; bus.agu_cmd_size = LSU_SIZE_W; bus.agu_cmd_usign = 1'b0;
    for (int t = 0; t < 20; t++) begin
      bus.agu_cmd_valid  = (acc < 2);
      bus.agu_cmd_itag   = (acc == 0) ? 4'd4 : 4'd5;
      bus.agu_cmd_addr   = (acc == 0) ? 16'h0100 : 16'h0104;
      bus.dtcm_rsp_valid = hs_prev;
      bus.dtcm_rsp_rdata = (nhs == 1) ? 32'h11111111 : 32'h22222222;
      @(negedge clk);
      if (bus.agu_cmd_valid && bus.agu_cmd_ready) acc++;
      hs_prev = bus.dtcm_cmd_valid && bus.dtcm_cmd_ready;
      if (hs_prev) begin
        if (nhs == 0) hs1 = t; else hs2 = t;
        nhs++;
      end
      if (bus.lsu_wbck_o_valid && bus.lsu_wbck_o_ready && nwb < 2) begin
        wb_itag[nwb] = bus.lsu_wbck_o_itag; wb_dat[nwb] = bus.lsu_wbck_o_data; nwb++;
      end
      cyc();
    end
    bus.agu_cmd_valid = 1'b0; bus.dtcm_rsp_valid = 1'b0;
    vecs++;
    if (hs2 - hs1 !== EXP_GAP) begin
      miss++; $display("FAIL b2b_gap got %0d expected %0d", hs2 - hs1, EXP_GAP);
    end
    vecs++;
    if (nwb !== 2) begin miss++; $display("FAIL b2b_wb_count got %0d expected 2", nwb); end
    vecs++;
    if ({wb_itag[0], wb_dat[0], wb_itag[1], wb_dat[1]} !== {4'd4, 32'h11111111, 4'd5, 32'h22222222}) begin
      miss++;
      $display("FAIL b2b_wb_data got %0d %h %0d %h expected 4 11111111 5 22222222",
               wb_itag[0], wb_dat[0], wb_itag[1], wb_dat[1]);
    end
  endtask

  initial begin
    bus.agu_cmd_valid = 1'b0; bus.agu_cmd_addr = '0; bus.agu_cmd_read = 1'b0;
    bus.agu_cmd_size = '0; bus.agu_cmd_usign = 1'b0; bus.agu_cmd_itag = '0;
    bus.agu_cmd_wdata = '0; bus.agu_cmd_wmask = '0; bus.agu_rsp_ready = 1'b0;
    bus.lsu_wbck_o_ready = 1'b0; bus.dtcm_cmd_ready = 1'b0; bus.dtcm_rsp_valid = 1'b0;
    bus.dtcm_rsp_rdata = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    cyc();
    rst_n = 1'b1;
    test_load_word();
    test_load_extend();
    test_store();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
